dejitter_multi: RTL

- Multi-channel, parametrised input debouncer/dejitter for slow external signals (buttons, LDAC/busy strobes, fault lines) ahead of the DAC control logic.
- Per channel:
  - synchronises the asynchronous input;
  - applies programmable polarity;
  - accepts a level change only after it has been stable for a run-time programmable number of clocks;
  - emits single-cycle rise/fall event pulses.
- Replaces fixed-length shift-register debouncing with a counter, so hold time is independent of register count.

---
 rtl/dejitter_pkg.sv | 16 +
 rtl/dejitter_chan.sv | 67 ++++++
 rtl/dejitter_multi.sv | 50 +++++
 3 files changed

// File: rtl/dejitter_pkg.sv
// dejitter_pkg: shared constants and helpers for the multi-channel dejitter.
//   C_DEFAULT_HOLD     - suggested hold_cnt for mechanical inputs
//   C_MIN_SYNC_STAGES  - smallest synchroniser depth that is metastability-safe
//   heff()             - effective stability threshold (0 is treated as 1)
package dejitter_pkg;

  localparam int C_DEFAULT_HOLD    = 1000;
  localparam int C_MIN_SYNC_STAGES = 2;
  localparam int C_MAX_COUNT_WIDTH = 32;

  // Threshold math is done at 32 bits so any C_COUNT_WIDTH up to 32 fits.
  function automatic logic [31:0] heff(input logic [31:0] hold);
    return (hold == 32'd0) ? 32'd1 : hold;
  endfunction

endpackage

// File: rtl/dejitter_chan.sv
// dejitter_chan: one debounced channel.
//   sys_clk, sys_rst_n : clock, synchronous active-low reset
//   raw                : asynchronous input bit
//   en                 : 0 freezes stable/pulses and clears the counter
//   hold_cnt           : required stable samples
//   stable             : debounced logical level
//   rise, fall         : single-cycle change events
module dejitter_chan
  import dejitter_pkg::*;
#(
  parameter int   COUNT_WIDTH = 16,
  parameter int   SYNC_STAGES = 2,
  parameter logic POLARITY    = 1'b0,
  parameter logic INIT        = 1'b0
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   raw,
  input  logic                   en,
  input  logic [COUNT_WIDTH-1:0] hold_cnt,
  output logic                   stable,
  output logic                   rise,
  output logic                   fall
);

  logic                   lvl;
  logic                   sq;
  logic [SYNC_STAGES-1:0] sync;
  logic [COUNT_WIDTH-1:0] cnt;
  logic [31:0]            thr;

  // Polarity is applied before synchronising so the chain resets to the
  // logical init level and no spurious change is seen out of reset.
  assign lvl = raw ^ POLARITY;
  assign sq  = sync[SYNC_STAGES-1];
  assign thr = heff(32'(hold_cnt)) - 32'd1;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sync   <= {SYNC_STAGES{INIT}};
      stable <= INIT;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      // Synchroniser keeps running even when disabled so re-enable sees
      // a current sample.
      sync <= {sync[SYNC_STAGES-2:0], lvl};
      rise <= 1'b0;
      fall <= 1'b0;
      if (!en) begin
        cnt <= '0;
      end else if (sq == stable) begin
        cnt <= '0;
      end else if (32'(cnt) >= thr) begin
        // ">=" so a lowered hold_cnt mid-count flips on the next edge.
        stable <= sq;
        cnt    <= '0;
        rise   <= sq;
        fall   <= ~sq;
      end else begin
        cnt <= cnt + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/dejitter_multi.sv
// dejitter_multi: C_CHANNELS independent debouncers with event pulses.
//   sys_clk, sys_rst_n : clock, synchronous active-low reset
//   signal_in          : raw asynchronous inputs
//   chan_en            : per-channel enable
//   hold_cnt           : required stable samples (0 behaves as 1)
//   signal_out         : debounced active-high levels
//   rise_pulse         : 1-cycle pulse on 0->1 of signal_out
//   fall_pulse         : 1-cycle pulse on 1->0 of signal_out
//   change_any         : OR of all event pulses, same cycle
module dejitter_multi
  import dejitter_pkg::*;
#(
  parameter int                    C_CHANNELS       = 4,
  parameter int                    C_COUNT_WIDTH    = 16,
  parameter int                    C_SYNC_STAGES    = 2,
  parameter logic [C_CHANNELS-1:0] C_INPUT_POLARITY = '0,
  parameter logic [C_CHANNELS-1:0] C_INIT_STATE     = '0
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [C_CHANNELS-1:0]    signal_in,
  input  logic [C_CHANNELS-1:0]    chan_en,
  input  logic [C_COUNT_WIDTH-1:0] hold_cnt,
  output logic [C_CHANNELS-1:0]    signal_out,
  output logic [C_CHANNELS-1:0]    rise_pulse,
  output logic [C_CHANNELS-1:0]    fall_pulse,
  output logic                     change_any
);

  for (genvar i = 0; i < C_CHANNELS; i++) begin : g_chan
    dejitter_chan #(
      .COUNT_WIDTH (C_COUNT_WIDTH),
      .SYNC_STAGES (C_SYNC_STAGES),
      .POLARITY    (C_INPUT_POLARITY[i]),
      .INIT        (C_INIT_STATE[i])
    ) u_chan (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .raw       (signal_in[i]),
      .en        (chan_en[i]),
      .hold_cnt  (hold_cnt),
      .stable    (signal_out[i]),
      .rise      (rise_pulse[i]),
      .fall      (fall_pulse[i])
    );
  end

  assign change_any = |(rise_pulse | fall_pulse);

endmodule
